// File: rtl/song_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : song_sequencer
// Purpose : Beat sequencer pacing song playback on a fixed tempo grid, with
//           pause, looping, runtime tempo select and missed-beat reporting.
// Revision: 1.0 - initial release
// ============================================================================
module song_sequencer #(
  parameter int SONG_LEN  = 65,
  parameter int CNT_W     = 8,
  parameter int TEMPO_DIV = 25000000,
  parameter int TEMPO_W   = 25
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             loopEn,
  input  logic [1:0]       tempoSel,
  input  logic             drawDone,
  output logic             shiftSong,
  output logic             addScore,
  output logic             beatIncremented,
  output logic             changeScore,
  output logic             beatMissed,
  output logic             songDone,
  output logic             busy,
  output logic [CNT_W-1:0] songCounter
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_START       = 3'd1,
    S_WAIT_BEAT   = 3'd2,
    S_PAUSED      = 3'd3,
    S_SHIFT       = 3'd4,
    S_DRAW        = 3'd5,
    S_WAIT_SCREEN = 3'd6
  } state_t;

  localparam logic [TEMPO_W-1:0] C_TEMPO_DIV = TEMPO_W'(TEMPO_DIV);
  localparam logic [CNT_W-1:0]   C_SONG_LEN  = CNT_W'(SONG_LEN);

  state_t             state_q, state_d;
  logic [TEMPO_W-1:0] tempo_cnt_q, tempo_cnt_d;
  logic [CNT_W-1:0]   song_cnt_q, song_cnt_d;
  logic               beat_missed_q, beat_missed_d;
  logic               song_done_q, song_done_d;

  logic [TEMPO_W-1:0] w_period;
  logic               w_tick;
  logic [TEMPO_W-1:0] w_tempo_next;
  logic [CNT_W-1:0]   w_cnt_inc;

  // The >= compare lets a shortened period tick at once instead of wrapping.
  assign w_period     = C_TEMPO_DIV >> tempoSel;
  assign w_tick       = ({1'b0, tempo_cnt_q} + (TEMPO_W+1)'(1)) >= {1'b0, w_period};
  assign w_tempo_next = w_tick ? '0 : tempo_cnt_q + TEMPO_W'(1);
  assign w_cnt_inc    = song_cnt_q + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tempo_cnt_q   <= '0;
      song_cnt_q    <= '0;
      beat_missed_q <= 1'b0;
      song_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tempo_cnt_q   <= tempo_cnt_d;
      song_cnt_q    <= song_cnt_d;
      beat_missed_q <= beat_missed_d;
      song_done_q   <= song_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tempo_cnt_d   = tempo_cnt_q;
    song_cnt_d    = song_cnt_q;
    beat_missed_d = 1'b0;
    song_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tempo_cnt_d = '0;
        if (start) state_d = S_START;
      end
      S_START: begin
        tempo_cnt_d = '0;
        song_cnt_d  = '0;
        state_d     = S_WAIT_BEAT;
      end
      S_WAIT_BEAT: begin
        tempo_cnt_d = w_tempo_next;
        if (pause)       state_d = S_PAUSED;
        else if (w_tick) state_d = S_SHIFT;
      end
      S_PAUSED: begin
        if (!pause) state_d = S_WAIT_BEAT;
      end
      S_SHIFT: begin
        tempo_cnt_d   = w_tempo_next;
        beat_missed_d = w_tick;
        state_d       = S_DRAW;
      end
      S_DRAW: begin
        tempo_cnt_d   = w_tempo_next;
        beat_missed_d = w_tick;
        state_d       = S_WAIT_SCREEN;
      end
      S_WAIT_SCREEN: begin
        tempo_cnt_d   = w_tempo_next;
        beat_missed_d = w_tick;
        if (drawDone) begin
          if (w_cnt_inc == C_SONG_LEN) begin
            song_done_d = 1'b1;
            if (loopEn) begin
              song_cnt_d = '0;
              state_d    = S_WAIT_BEAT;
            end else begin
              song_cnt_d = w_cnt_inc;
              state_d    = S_IDLE;
            end
          end else begin
            song_cnt_d = w_cnt_inc;
            state_d    = S_WAIT_BEAT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign shiftSong       = (state_q == S_SHIFT);
  assign addScore        = (state_q == S_SHIFT);
  assign beatIncremented = (state_q == S_DRAW);
  assign changeScore     = (state_q == S_WAIT_SCREEN);
  assign beatMissed      = beat_missed_q;
  assign songDone        = song_done_q;
  assign busy            = (state_q != S_IDLE);
  assign songCounter     = song_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_song_sequencer
// Purpose : Self-checking bench: song-level vector table, directed corner
//           sequences and a randomized run against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_song_sequencer;

  localparam int SONG_LEN  = 3;
  localparam int CNT_W     = 8;
  localparam int TEMPO_DIV = 8;
  localparam int TEMPO_W   = 4;

  logic             clock = 1'b0;
  logic             reset, start, pause, loopEn, drawDone;
  logic [1:0]       tempoSel;
  logic             shiftSong, addScore, beatIncremented, changeScore;
  logic             beatMissed, songDone, busy;
  logic [CNT_W-1:0] songCounter;

  int tests = 0;
  int fails = 0;

  song_sequencer #(
    .SONG_LEN (SONG_LEN),
    .CNT_W    (CNT_W),
    .TEMPO_DIV(TEMPO_DIV),
    .TEMPO_W  (TEMPO_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .pause          (pause),
    .loopEn         (loopEn),
    .tempoSel       (tempoSel),
    .drawDone       (drawDone),
    .shiftSong      (shiftSong),
    .addScore       (addScore),
    .beatIncremented(beatIncremented),
    .changeScore    (changeScore),
    .beatMissed     (beatMissed),
    .songDone       (songDone),
    .busy           (busy),
    .songCounter    (songCounter)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b0; pause = 1'b0; loopEn = 1'b0;
    tempoSel = 2'd0; drawDone = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [6:0] pulses();
    return {shiftSong, addScore, beatIncremented, changeScore, beatMissed, songDone, busy};
  endfunction

  // One whole song: cycle numbers are counted from the cycle start is high.
  typedef struct {
    int sel, dly, loop_en;
    int s0, s1, s2, s3;
    int done_at, miss, cnt_at_done, busy_at_done;
  } song_vec_t;

  song_vec_t vecs[5];

  task automatic run_song(input song_vec_t v, input int idx);
    int shift_at[4];
    int ns = 0, dd_at = -1, done_at = -1, miss = 0, cnt_d = -1, busy_d = -1;
    for (int i = 0; i < 4; i++) shift_at[i] = -1;
    do_reset();
    tempoSel = 2'(v.sel);
    loopEn   = 1'(v.loop_en);
    start    = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      if (shiftSong && ns < 4) begin shift_at[ns] = k; ns++; end
      if (beatIncremented) dd_at = k + v.dly;
      if (beatMissed && done_at < 0) miss++;
      if (songDone && done_at < 0) begin
        done_at = k; cnt_d = int'(songCounter); busy_d = int'(busy);
      end
      drawDone = (k == dd_at);
    end
    drawDone = 1'b0;
    check($sformatf("v%0d shift1", idx), shift_at[0], v.s0);
    check($sformatf("v%0d shift2", idx), shift_at[1], v.s1);
    check($sformatf("v%0d shift3", idx), shift_at[2], v.s2);
    check($sformatf("v%0d shift4", idx), shift_at[3], v.s3);
    check($sformatf("v%0d done_cycle", idx), done_at, v.done_at);
    check($sformatf("v%0d missed", idx), miss, v.miss);
    check($sformatf("v%0d count_at_done", idx), cnt_d, v.cnt_at_done);
    check($sformatf("v%0d busy_at_done", idx), busy_d, v.busy_at_done);
  endtask

  // Behavioural model: the song as a phase number plus a beat-grid position.
  localparam int PH_IDLE = 0, PH_ARM = 1, PH_WAIT = 2, PH_HOLD = 3,
                 PH_SHIFT = 4, PH_DRAW = 5, PH_SCREEN = 6;
  int m_phase, m_grid, m_beats;
  bit m_missed, m_done;

  task automatic model_clear();
    m_phase = PH_IDLE; m_grid = 0; m_beats = 0; m_missed = 0; m_done = 0;
  endtask

  task automatic model_step();
    int  period = TEMPO_DIV >> tempoSel;
    bit  hit    = (m_grid + 1 >= period);
    int  grid_n = hit ? 0 : m_grid + 1;
    bool_busy: begin end
    m_missed = 0;
    m_done   = 0;
    if (reset) begin
      model_clear();
    end else if (m_phase == PH_IDLE) begin
      m_grid = 0;
      if (start) m_phase = PH_ARM;
    end else if (m_phase == PH_ARM) begin
      m_grid = 0; m_beats = 0; m_phase = PH_WAIT;
    end else if (m_phase == PH_WAIT) begin
      m_grid = grid_n;
      if (pause) m_phase = PH_HOLD;
      else if (hit) m_phase = PH_SHIFT;
    end else if (m_phase == PH_HOLD) begin
      if (!pause) m_phase = PH_WAIT;
    end else begin
      m_grid   = grid_n;
      m_missed = hit;
      if (m_phase != PH_SCREEN) m_phase = m_phase + 1;
      else if (drawDone) begin
        m_beats = m_beats + 1;
        m_phase = PH_WAIT;
        if (m_beats == SONG_LEN) begin
          m_done = 1;
          if (loopEn) m_beats = 0;
          else m_phase = PH_IDLE;
        end
      end
    end
  endtask

  function automatic logic [14:0] model_out();
    return {m_phase == PH_SHIFT, m_phase == PH_SHIFT, m_phase == PH_DRAW,
            m_phase == PH_SCREEN, m_missed, m_done, m_phase != PH_IDLE, 8'(m_beats)};
  endfunction

  initial begin
    int first_shift, bad, k;
    bit reached;
    reset = 1'b1; start = 1'b0; pause = 1'b0; loopEn = 1'b0;
    tempoSel = 2'd0; drawDone = 1'b0;

    vecs[0] = '{sel:0, dly:2, loop_en:0, s0:10, s1:18, s2:26, s3:-1, done_at:30, miss:0, cnt_at_done:3, busy_at_done:0};
    vecs[1] = '{sel:1, dly:2, loop_en:0, s0:6,  s1:14, s2:22, s3:-1, done_at:26, miss:3, cnt_at_done:3, busy_at_done:0};
    vecs[2] = '{sel:0, dly:5, loop_en:0, s0:10, s1:18, s2:26, s3:-1, done_at:33, miss:0, cnt_at_done:3, busy_at_done:0};
    vecs[3] = '{sel:2, dly:5, loop_en:0, s0:4,  s1:12, s2:20, s3:-1, done_at:27, miss:9, cnt_at_done:3, busy_at_done:0};
    vecs[4] = '{sel:0, dly:2, loop_en:1, s0:10, s1:18, s2:26, s3:34, done_at:30, miss:0, cnt_at_done:0, busy_at_done:1};

    // Reset state
    do_reset();
    check("reset_outputs", 32'(pulses()), 32'd0);
    check("reset_count", 32'(songCounter), 32'd0);

    for (int i = 0; i < 5; i++) run_song(vecs[i], i);

    // Pause while in WAIT_BEAT, held 20 cycles; tempo position resumes, not restarts
    do_reset();
    start = 1'b1; first_shift = -1; bad = 0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      if (shiftSong && first_shift < 0) first_shift = k;
      if (k >= 5 && k <= 24 && (!busy || shiftSong || beatMissed)) bad++;
      pause = (k >= 4 && k <= 23);
    end
    pause = 1'b0;
    check("pause_hold", bad, 0);
    check("pause_resume_shift", first_shift, 30);

    // Mid-count tempo speed-up ticks on the next cycle
    do_reset();
    start = 1'b1; first_shift = -1;
    for (k = 1; k <= 15; k++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      if (shiftSong && first_shift < 0) first_shift = k;
      if (k == 7) tempoSel = 2'd3;
    end
    check("tempo_speedup_shift", first_shift, 8);

    // Reset in WAIT_SCREEN with two beats done
    do_reset();
    start = 1'b1; reached = 0;
    begin
      int dd_at = -1;
      for (k = 1; k <= 60 && !reached; k++) begin
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        if (beatIncremented) dd_at = k + 2;
        drawDone = (k == dd_at);
        if (changeScore && songCounter == 8'd2) reached = 1;
      end
    end
    check("reach_ws_count2", 32'(reached), 32'd1);
    reset = 1'b1; drawDone = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("midsong_reset_outputs", 32'(pulses()), 32'd0);
    check("midsong_reset_count", 32'(songCounter), 32'd0);
    reset = 1'b0; bad = 0;
    repeat (5) begin
      @(posedge clock);
      @(negedge clock);
      if (songDone || busy) bad++;
    end
    check("midsong_reset_quiet", bad, 0);

    // drawDone held in IDLE has no effect
    drawDone = 1'b1; bad = 0;
    repeat (10) begin
      @(posedge clock);
      @(negedge clock);
      if (pulses() != 7'd0 || songCounter != 8'd0) bad++;
    end
    drawDone = 1'b0;
    check("idle_drawdone_ignored", bad, 0);

    // Randomized run against the model
    do_reset();
    model_clear();
    for (int n = 0; n < 4000; n++) begin
      reset    = ($urandom_range(0, 299) == 0);
      start    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      if ($urandom_range(0, 39) == 0) loopEn = ~loopEn;
      if ($urandom_range(0, 59) == 0) tempoSel = 2'($urandom_range(0, 3));
      drawDone = ($urandom_range(0, 2) == 0);
      @(posedge clock);
      model_step();
      @(negedge clock);
      check($sformatf("rand_cycle%0d", n),
            32'({shiftSong, addScore, beatIncremented, changeScore, beatMissed,
                 songDone, busy, songCounter}),
            32'(model_out()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
